// File: rtl/as_mac_engine.sv
// rtl/as_mac_engine.sv - multi-accumulator fixed-point MAC engine with sequential shift-add multiplier
module as_mac_engine #(
    parameter int n    = 8,
    parameter int FRAC = 7,
    parameter int NACC = 2,
    parameter int SAT  = 1,
    localparam int SEL_W = $clog2(NACC)
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [SEL_W-1:0]  acc_sel,
    input  logic [n-1:0]      a,
    input  logic [n-1:0]      b,
    output logic              busy,
    output logic              done,
    output logic [n-1:0]      result,
    output logic              z,
    output logic              ovf,
    output logic [NACC*n-1:0] acc_out
);

    typedef enum logic [1:0] {IDLE, MULT, WRITE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MACC = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b11;
    localparam int CNT_W = ($clog2(n) + 1 > 5) ? $clog2(n) + 1 : 5;
    localparam int PW    = 2 * n;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic [SEL_W-1:0] sel_q;
    logic [n-1:0]     mplier_q;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    prod_q;
    logic [n-1:0]     acc_q [NACC];
    logic [n-1:0]     result_q;
    logic             z_q, ovf_q, done_q;

    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [n-1:0]     wr_val;
    logic             wr_ovf;
    logic [n-1:0]     acc_cur;
    logic [PW-1:0]    p;
    logic [PW:0]      v;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_sel  = sel_q;
        wr_val  = '0;
        wr_ovf  = 1'b0;
        acc_cur = '0;
        // Out-of-range selects read as zero and match no accumulator on write.
        for (int k = 0; k < NACC; k++) begin
            if (sel_q == SEL_W'(k)) acc_cur = acc_q[k];
        end
        p = prod_q >> FRAC;
        v = ((op_q == OP_MACC) ? {{(PW + 1 - n){1'b0}}, acc_cur} : '0) + {1'b0, p};
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_LOAD || op == OP_CLR) begin
                        wr_en  = 1'b1;
                        wr_sel = acc_sel;
                        wr_val = (op == OP_LOAD) ? a : '0;
                    end else begin
                        state_d = MULT;
                    end
                end
            end
            MULT: begin
                if (cnt_q == CNT_W'(n - 1)) state_d = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
                wr_en   = 1'b1;
                wr_ovf  = |v[PW:n];
                wr_val  = (wr_ovf && SAT != 0) ? '1 : v[n-1:0];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sel_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            result_q <= '0;
            z_q      <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            for (int k = 0; k < NACC; k++) acc_q[k] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= wr_en;
            if (state_q == IDLE && start) begin
                op_q     <= op;
                sel_q    <= acc_sel;
                mplier_q <= a;
                mcand_q  <= {{n{1'b0}}, b};
                prod_q   <= '0;
                cnt_q    <= '0;
            end else if (state_q == MULT) begin
                // Multiplier shifts right, multiplicand left: one partial product per cycle.
                if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                mplier_q <= mplier_q >> 1;
                mcand_q  <= mcand_q << 1;
                cnt_q    <= cnt_q + 1'b1;
            end
            if (wr_en) begin
                result_q <= wr_val;
                z_q      <= (wr_val == '0);
                ovf_q    <= wr_ovf;
                for (int k = 0; k < NACC; k++) begin
                    if (wr_sel == SEL_W'(k)) acc_q[k] <= wr_val;
                end
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign z      = z_q;
    assign ovf    = ovf_q;

    for (genvar k = 0; k < NACC; k++) begin : g_pack
        assign acc_out[k*n +: n] = acc_q[k];
    end

endmodule

// File: tb/tb_as_mac_engine.sv
// tb/tb_as_mac_engine.sv - table-driven scoreboard bench for as_mac_engine (SAT=1 and SAT=0 instances)
module tb_as_mac_engine;

    localparam int N = 8;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MACC = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [0:0]  acc_sel = '0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;

    logic        busy_s, done_s, z_s, ovf_s;
    logic [7:0]  result_s;
    logic [15:0] acc_out_s;
    logic        busy_w, done_w, z_w, ovf_w;
    logic [7:0]  result_w;
    logic [15:0] acc_out_w;

    as_mac_engine #(.n(N), .FRAC(7), .NACC(2), .SAT(1)) u_sat (
        .clk(clk), .n_reset(n_reset), .start(start), .op(op), .acc_sel(acc_sel),
        .a(a), .b(b), .busy(busy_s), .done(done_s), .result(result_s),
        .z(z_s), .ovf(ovf_s), .acc_out(acc_out_s)
    );

    as_mac_engine #(.n(N), .FRAC(7), .NACC(2), .SAT(0)) u_wrap (
        .clk(clk), .n_reset(n_reset), .start(start), .op(op), .acc_sel(acc_sel),
        .a(a), .b(b), .busy(busy_w), .done(done_w), .result(result_w),
        .z(z_w), .ovf(ovf_w), .acc_out(acc_out_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  res_s;
        logic        ovf_s;
        logic [15:0] acc_s;
        logic [7:0]  res_w;
        logic        ovf_w;
        logic [15:0] acc_w;
    } vec_t;

    vec_t vecs [14];
    int   sb [$];
    int   checks = 0;
    int   errors = 0;
    int   dones = 0;
    int   pushes = 0;
    int   mon_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_reset) begin
            if (busy_s && done_s) chk("busy_done_overlap", 32'(busy_s & done_s), 32'd0);
            if (done_s) begin
                dones++;
                chk("wrap_done_aligned", 32'(done_w), 32'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done_s), 32'd0);
                end else begin
                    mon_idx = sb.pop_front();
                    chk($sformatf("res_s_%0d", mon_idx), 32'(result_s), 32'(vecs[mon_idx].res_s));
                    chk($sformatf("z_s_%0d", mon_idx), 32'(z_s), 32'(vecs[mon_idx].res_s == 8'd0));
                    chk($sformatf("ovf_s_%0d", mon_idx), 32'(ovf_s), 32'(vecs[mon_idx].ovf_s));
                    chk($sformatf("acc_s_%0d", mon_idx), 32'(acc_out_s), 32'(vecs[mon_idx].acc_s));
                    chk($sformatf("res_w_%0d", mon_idx), 32'(result_w), 32'(vecs[mon_idx].res_w));
                    chk($sformatf("z_w_%0d", mon_idx), 32'(z_w), 32'(vecs[mon_idx].res_w == 8'd0));
                    chk($sformatf("ovf_w_%0d", mon_idx), 32'(ovf_w), 32'(vecs[mon_idx].ovf_w));
                    chk($sformatf("acc_w_%0d", mon_idx), 32'(acc_out_w), 32'(vecs[mon_idx].acc_w));
                end
            end
        end
    end

    task automatic drive_start(input int i);
        op      = vecs[i].op;
        acc_sel = vecs[i].sel;
        a       = vecs[i].a;
        b       = vecs[i].b;
        start   = 1'b1;
        sb.push_back(i);
        pushes++;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 2'($urandom);
        acc_sel = 1'($urandom);
        a       = 8'($urandom);
        b       = 8'($urandom);
    endtask

    task automatic wait_done(input string name, output int nb);
        int cyc;
        nb  = 0;
        cyc = 0;
        while (!done_s && cyc < 30) begin
            @(negedge clk);
            if (busy_s) nb++;
            cyc++;
        end
        chk({name, "_timeout"}, 32'(cyc < 30), 32'd1);
    endtask

    task automatic run_op(input int i);
        int nb;
        int exp_busy;
        exp_busy = (vecs[i].op == OP_LOAD || vecs[i].op == OP_CLR) ? 0 : N + 1;
        @(negedge clk);
        drive_start(i);
        wait_done($sformatf("op_%0d", i), nb);
        chk($sformatf("busy_cycles_%0d", i), 32'(nb), 32'(exp_busy));
    endtask

    initial begin
        int nb;
        int dones_before;

        vecs[0]  = '{OP_LOAD, 1'b0, 8'd6,   8'h00, 8'd6,   1'b0, 16'h0006, 8'd6,   1'b0, 16'h0006};
        vecs[1]  = '{OP_MACC, 1'b0, 8'd20,  8'h60, 8'd21,  1'b0, 16'h0015, 8'd21,  1'b0, 16'h0015};
        vecs[2]  = '{OP_MUL,  1'b1, 8'd255, 8'hFF, 8'd255, 1'b1, 16'hFF15, 8'd252, 1'b1, 16'hFC15};
        vecs[3]  = '{OP_LOAD, 1'b1, 8'd250, 8'h00, 8'd250, 1'b0, 16'hFA15, 8'd250, 1'b0, 16'hFA15};
        vecs[4]  = '{OP_MACC, 1'b1, 8'd20,  8'h80, 8'd255, 1'b1, 16'hFF15, 8'd14,  1'b1, 16'h0E15};
        vecs[5]  = '{OP_CLR,  1'b1, 8'd77,  8'h00, 8'd0,   1'b0, 16'h0015, 8'd0,   1'b0, 16'h0015};
        vecs[6]  = '{OP_MUL,  1'b0, 8'd0,   8'd200, 8'd0,  1'b0, 16'h0000, 8'd0,   1'b0, 16'h0000};
        vecs[7]  = '{OP_MACC, 1'b0, 8'd255, 8'h01, 8'd1,   1'b0, 16'h0001, 8'd1,   1'b0, 16'h0001};
        vecs[8]  = '{OP_MUL,  1'b0, 8'd200, 8'h80, 8'd200, 1'b0, 16'h00C8, 8'd200, 1'b0, 16'h00C8};
        vecs[9]  = '{OP_MACC, 1'b0, 8'd100, 8'h40, 8'd250, 1'b0, 16'h00FA, 8'd250, 1'b0, 16'h00FA};
        vecs[10] = '{OP_MACC, 1'b0, 8'd6,   8'h80, 8'd255, 1'b1, 16'h00FF, 8'd0,   1'b1, 16'h0000};
        vecs[11] = '{OP_MACC, 1'b0, 8'd10,  8'h80, 8'd255, 1'b1, 16'h00FF, 8'd10,  1'b0, 16'h000A};
        vecs[12] = '{OP_MUL,  1'b1, 8'd4,   8'h80, 8'd4,   1'b0, 16'h04FF, 8'd4,   1'b0, 16'h040A};
        vecs[13] = '{OP_MACC, 1'b0, 8'd50,  8'h80, 8'd0,   1'b0, 16'h0000, 8'd0,   1'b0, 16'h0000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_s), 32'd0);
        chk("rst_done", 32'(done_s), 32'd0);
        chk("rst_result", 32'(result_s), 32'd0);
        chk("rst_z", 32'(z_s), 32'd1);
        chk("rst_ovf", 32'(ovf_s), 32'd0);
        chk("rst_acc", 32'(acc_out_s), 32'd0);
        chk("rst_acc_w", 32'(acc_out_w), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i <= 10; i++) run_op(i);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        drive_start(11);
        repeat (3) @(negedge clk);
        op = OP_LOAD; acc_sel = 1'b1; a = 8'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore", nb);
        drive_start(12);
        chk("done_cycle_start_busy", 32'(busy_s), 32'd1);
        chk("done_cycle_start_nodone", 32'(done_s), 32'd0);
        wait_done("done_cycle_start", nb);

        // Reset on the 4th busy cycle aborts the op without a write or done.
        @(negedge clk);
        op = vecs[13].op; acc_sel = vecs[13].sel; a = vecs[13].a; b = vecs[13].b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(busy_s), 32'd1);
        dones_before = dones;
        n_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy_s), 32'd0);
        chk("abort_done", 32'(done_s), 32'd0);
        chk("abort_acc", 32'(acc_out_s), 32'(vecs[13].acc_s));
        chk("abort_acc_w", 32'(acc_out_w), 32'(vecs[13].acc_w));
        chk("abort_z", 32'(z_s), 32'd1);
        chk("abort_result", 32'(result_s), 32'd0);
        chk("abort_ovf", 32'(ovf_s), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_done", 32'(dones), 32'(dones_before));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(dones), 32'(pushes));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/as_mac_engine.md
Name: as_mac_engine

Overview:
- Parametrised, multi-cycle multiply-accumulate engine; the next generation of the processor's single-accumulator ALU datapath.
- Holds NACC independent accumulators.
- Performs fixed-point multiply (unsigned coefficient, FRAC fractional bits) with a sequential shift-add multiplier.
- Optional saturation; start/busy/done handshake toward the control unit.

Parameters:
- n, 8, data and accumulator width in bits (n >= 4)
- FRAC, 7, fractional bits of coefficient b (0 <= FRAC < n); b = 8'b01100000 is 0.75 at defaults
- NACC, 2, number of accumulators (NACC >= 2); SEL_W = $clog2(NACC)
- SAT, 1, 1 = saturate results to 2^n-1; 0 = wrap modulo 2^n

Ports:
- clk  in  1  system clock, rising edge
- n_reset  in  1  synchronous, active-low reset
- start  in  1  request operation; sampled only in IDLE
- op  in  2  00 LOAD, 01 MACC, 10 MUL, 11 CLR
- acc_sel  in  SEL_W  target accumulator index
- a  in  n  unsigned operand (pixel/data)
- b  in  n  unsigned fixed-point coefficient, FRAC fractional bits
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when the target accumulator is written
- result  out  n  value last written to an accumulator
- z  out  1  result == 0
- ovf  out  1  last write saturated (SAT=1) or wrapped (SAT=0)
- acc_out  out  NACC*n  all accumulators packed; acc k at [k*n +: n]

Behaviour:
- Reset (n_reset low at a clk edge):
  - All accumulators 0, result 0, z 1, ovf 0, busy 0, done 0.
  - State returns to IDLE; an in-flight op is aborted with no write and no done.
- States:
  - IDLE: busy=0.
  - MULT: busy=1; a 5-bit-or-wider iteration counter runs 0..n-1.
  - WRITE: busy=1, lasts 1 cycle.
- Operand capture: on the edge where start=1 in IDLE, op, acc_sel, a and b are latched. Inputs may change afterwards.
- LOAD / CLR:
  - At the start edge, acc[sel] <= a (LOAD) or 0 (CLR); result/z/ovf update (ovf=0).
  - done is high for the following cycle. State stays IDLE. Latency 1.
- MUL / MACC:
  - Start edge -> MULT. Each MULT cycle adds (b shifted by iteration) into a 2n-bit product if a[iter]==1.
  - After n MULT cycles -> WRITE.
  - At the WRITE->IDLE edge:
    - p = product >> FRAC (floor).
    - MUL: v = p. MACC: v = acc[sel] + p, computed at 2n+1 bits.
    - If v > 2^n-1: ovf=1 and the stored value is 2^n-1 (SAT=1) or v mod 2^n (SAT=0); otherwise ovf=0.
  - done is high for the cycle after that edge. Start-to-done latency is n+2 edges (n+1 busy cycles).
- done and busy are never high together. start is ignored while busy=1; a start in the done cycle is accepted.
- acc_sel >= NACC (non-power-of-2 NACC): no accumulator is written, but result/z/ovf update and done pulses normally.
- Only acc[sel] changes per op; the other accumulators hold.
- acc_out is registered state, combinationally packed; there is no extra output latency.

Test Plan (n=8, FRAC=7, NACC=2, SAT=1 unless noted):
1. LOAD sel=0, a=6 -> next cycle done=1, acc0=6, result=6, z=0, ovf=0, busy never high.
2. MACC sel=0, a=20, b=8'b01100000 (acc0=6) -> busy for 9 cycles, then done pulse, acc0=21 (6+15), acc1 unchanged, ovf=0.
3. MUL sel=1, a=255, b=255 -> product 65025>>7=508 -> acc1=255, ovf=1; with SAT=0 rebuild -> acc1=252, ovf=1.
4. LOAD acc1=250, then MACC sel=1, a=20, b=8'h80 (1.0) -> 270 -> acc1=255, ovf=1. Then CLR sel=1 -> acc1=0, z=1, ovf=0, acc0 unchanged.
5. Start MACC, pulse start with op=LOAD while busy -> ignored, exactly one done. Issue a new start in the done cycle -> accepted; busy next cycle.
6. Start MACC, drive n_reset=0 on the 4th busy cycle -> next edge: busy=0, done never pulses, all accumulators 0, z=1.
